alu_mdu: RTL and testbench

Iterative multiply/divide unit that extends the datapath ALU with MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO, holding results in internal HI/LO registers. Operations are multicycle, with a start/busy/done handshake that the multicycle controller uses to stall. It sits beside the combinational ALU, sharing its operand buses, and drives HI/LO into the register-writeback mux for MFHI/MFLO.

---
 rtl/alu_mdu.sv | 140 ++++++++++++++
 tb/tb_alu_mdu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU + MTHI/MTLO unit: WIDTH+1 cycles to DONE, start ignored while busy.
// Signed MULT/DIV sign handling only exists when ALU_MDU_SIGNED_EN is defined; otherwise they alias the unsigned ops.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] param1,
  input  logic [WIDTH-1:0] param2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_a;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;    // product accumulator; low half is dividend/quotient for divide
  logic [WIDTH-1:0]   r_rem;

  logic [WIDTH-1:0]   w_p1_mag;
  logic [WIDTH-1:0]   w_p2_mag;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

`ifdef ALU_MDU_SIGNED_EN
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               w_p1_neg;
  logic               w_p2_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_p1_neg = op[0] & param1[WIDTH-1];
  assign w_p2_neg = op[0] & param2[WIDTH-1];
  assign w_p1_mag = w_p1_neg ? -param1 : param1;
  assign w_p2_mag = w_p2_neg ? -param2 : param2;
  assign w_prod   = r_neg_res ? -r_acc : r_acc;
  assign w_quo    = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? -r_rem : r_rem;
  assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
`else
  assign w_p1_mag = param1;
  assign w_p2_mag = param2;
  assign w_fix_hi = r_is_div ? r_rem : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_acc[WIDTH-1:0];
`endif

  assign w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_trial = {r_rem, r_acc[WIDTH-1]};
  assign w_ge    = w_trial >= {1'b0, r_a};
  // Restored remainder is always below 2^WIDTH, so the subtraction can drop the top bit.
  assign w_diff  = w_trial[WIDTH-1:0] - r_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_dbz       <= 1'b0;
      r_a         <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef ALU_MDU_SIGNED_EN
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          r_state     <= S_IDLE;
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_is_div <= op[1];
                r_dbz    <= op[1] && (param2 == '0);
                r_a      <= op[1] ? w_p2_mag : w_p1_mag;
                r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_p1_mag : w_p2_mag)};
                r_rem    <= '0;
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= S_CALC;
`ifdef ALU_MDU_SIGNED_EN
                r_neg_res <= w_p1_neg ^ w_p2_neg;
                r_neg_rem <= w_p1_neg;
`endif
              end
              3'b100:  hi <= param1;
              3'b101:  lo <= param1;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (r_is_div) begin
            r_rem             <= w_ge ? w_diff : w_trial[WIDTH-1:0];
            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_add, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          hi          <= w_fix_hi;
          lo          <= w_fix_lo;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= r_dbz;
          r_state     <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: latency, results, handshake corners and async reset.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] param1;
  logic [W-1:0] param2;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_total = 0;
  int n_bad   = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .param1(param1), .param2(param2),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one rising edge (the accept edge E0).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; param1 = a; param2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after edge E(skip); checks FIX at E(W) then DONE contents after E(W+1).
  task automatic wait_result(input string tag, input int skip, input logic [W-1:0] ehi,
                             input logic [W-1:0] elo, input logic edbz);
    chk({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
    repeat (W - skip) @(posedge clk);
    #1;
    chk({tag, "_done_early"}, {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; param1 = '0; param2 = '0;
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1 chk("multu_done_pulse", {31'b0, done}, 32'd0);

    issue(3'b001, 32'hFFFF_FFFD, 32'd5);
`ifdef ALU_MDU_SIGNED_EN
    wait_result("mult_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
`else
    wait_result("mult_neg", 0, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
`endif

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
`ifdef ALU_MDU_SIGNED_EN
    wait_result("div_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
`else
    wait_result("div_neg", 0, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
`endif

    issue(3'b010, 32'd10, 32'd0);
    wait_result("divu_zero", 0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk);
    #1 chk("dbz_pulse", {31'b0, div_by_zero}, 32'd0);

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    start = 1'b1; op = 3'b100; param1 = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_hold", lo, 32'hFFFF_FFFF);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    op = 3'b101; param1 = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_hold", hi, 32'h1234_5678);
    chk("mtlo_done", {31'b0, done}, 32'd0);

    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    chk("op6_busy", {31'b0, busy}, 32'd0);
    chk("op6_hi", hi, 32'h1234_5678);
    chk("op6_lo", lo, 32'h9ABC_DEF0);

    // DIVU 100/7 with a MULTU start pulsed at edge E5; it must be ignored.
    issue(3'b010, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'b000; param1 = 32'd3; param2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; param1 = 32'd0; param2 = 32'd0;
    wait_result("divu_ign", 5, 32'd2, 32'd14, 1'b0);

    // Start held during DONE: accepted at the DONE-exit edge.
    start = 1'b1; op = 3'b000; param1 = 32'd3; param2 = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_done_drop", {31'b0, done}, 32'd0);
    chk("b2b_lo_hold", lo, 32'd14);
    wait_result("b2b_multu", 0, 32'd0, 32'd12, 1'b0);

    // Async reset at cycle 10 of a MULT.
    issue(3'b001, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b000, 32'd6, 32'd7);
    wait_result("post_rst", 0, 32'd0, 32'd42, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
